// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_scheduler
// Description : RGB LED matrix sequencer. Time-multiplexes the R/G/B sink
//               phases and PWMs the LED columns from a double-buffered
//               brightness store. The host writes the shadow bank, and a
//               commit copies it to the active bank in one edge at frame end.
//               Optional macro LED_DEADTIME_EN inserts DEAD_TICKS blanking
//               clocks after every phase.
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int NUM_LEDS   = 11,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 1,
    parameter int DEAD_TICKS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [3:0]          wr_led,
    input  logic [1:0]          wr_chan,
    input  logic [PWM_BITS-1:0] wr_value,
    input  logic                commit,
    output logic                commit_pending,
    output logic                frame_start,
    output logic [1:0]          phase,
    output logic [NUM_LEDS-1:0] ledc,
    output logic [2:0]          ledrgb
);

    typedef enum logic [1:0] {
        PH_R    = 2'd0,
        PH_G    = 2'd1,
        PH_B    = 2'd2,
        PH_DEAD = 2'd3
    } state_t;

    localparam int                  c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] c_cnt_last = '1;

    generate
        if (NUM_LEDS < 1 || NUM_LEDS > 16 || PWM_BITS < 1 || PRESCALE < 1 || DEAD_TICKS < 1) begin : g_bad_params
            $error("led_frame_scheduler: parameter out of range");
        end
    endgenerate

    state_t              r_state;
    logic [PWM_BITS-1:0] r_cnt;
    logic [c_pre_w-1:0]  r_pre;
    logic                r_wrapped;   // at least one full frame has completed since reset
    logic [PWM_BITS-1:0] r_shadow [NUM_LEDS][3];
    logic [PWM_BITS-1:0] r_active [NUM_LEDS][3];

    logic                w_tick_end;
    logic                w_frame_end;
    logic [NUM_LEDS-1:0] w_ledc;
    logic [2:0]          w_rgb;

`ifdef LED_DEADTIME_EN
    localparam int                  c_dead_w    = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [c_dead_w-1:0] c_dead_last = c_dead_w'(DEAD_TICKS - 1);
    logic [c_dead_w-1:0] r_dead;
    state_t              r_next;      // colour phase that follows the current blanking
`endif

    function automatic state_t f_succ(input state_t s);
        case (s)
            PH_R:    f_succ = PH_G;
            PH_G:    f_succ = PH_B;
            default: f_succ = PH_R;
        endcase
    endfunction

    assign wr_ready   = ~commit_pending;
    assign w_tick_end = (r_pre == c_pre_last);

`ifdef LED_DEADTIME_EN
    assign w_frame_end = (r_state == PH_DEAD) && (r_next == PH_R) && (r_dead == c_dead_last);
`else
    assign w_frame_end = (r_state == PH_B) && w_tick_end && (r_cnt == c_cnt_last);
`endif

    // Column compare against the active bank for the current colour; dark when blanking
    always_comb begin
        w_ledc = '0;
        for (int l = 0; l < NUM_LEDS; l++) begin
            for (int c = 0; c < 3; c++) begin
                if (r_state == 2'(c)) begin
                    w_ledc[l] = (r_cnt < r_active[l][c]);
                end
            end
        end
    end

    // One-hot sink select for the current phase
    always_comb begin
        case (r_state)
            PH_R:    w_rgb = 3'b001;
            PH_G:    w_rgb = 3'b010;
            PH_B:    w_rgb = 3'b100;
            default: w_rgb = 3'b000;
        endcase
    end

    // Phase sequencer with prescaled tick counter and registered LED outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PH_R;
            r_cnt       <= '0;
            r_pre       <= '0;
            r_wrapped   <= 1'b0;
            phase       <= 2'd0;
            ledrgb      <= 3'b000;
            ledc        <= '0;
            frame_start <= 1'b0;
`ifdef LED_DEADTIME_EN
            r_dead      <= '0;
            r_next      <= PH_G;
`endif
        end else begin
            phase       <= r_state;
            ledrgb      <= w_rgb;
            ledc        <= w_ledc;
            frame_start <= r_wrapped && (r_state == PH_R) && (r_cnt == '0) && (r_pre == '0);
            if (w_frame_end) begin
                r_wrapped <= 1'b1;
            end
`ifdef LED_DEADTIME_EN
            if (r_state == PH_DEAD) begin
                if (r_dead == c_dead_last) begin
                    r_dead  <= '0;
                    r_state <= r_next;
                end else begin
                    r_dead <= r_dead + 1'b1;
                end
            end else if (w_tick_end) begin
                r_pre <= '0;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_cnt_last) begin
                    r_state <= PH_DEAD;
                    r_next  <= f_succ(r_state);
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
`else
            if (w_tick_end) begin
                r_pre <= '0;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_cnt_last) begin
                    r_state <= f_succ(r_state);
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
`endif
        end
    end

    // Host writes into the shadow bank; pending commit swaps banks at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pending <= 1'b0;
            for (int l = 0; l < NUM_LEDS; l++) begin
                for (int c = 0; c < 3; c++) begin
                    r_shadow[l][c] <= '0;
                    r_active[l][c] <= '0;
                end
            end
        end else begin
            if (wr_valid && !commit_pending) begin
                for (int l = 0; l < NUM_LEDS; l++) begin
                    for (int c = 0; c < 3; c++) begin
                        if (wr_led == 4'(l) && wr_chan == 2'(c)) begin
                            r_shadow[l][c] <= wr_value;
                        end
                    end
                end
            end
            if (w_frame_end && commit_pending) begin
                r_active       <= r_shadow;
                commit_pending <= 1'b0;
            end else if (commit && !commit_pending) begin
                commit_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
